fc_feature_packer: RTL and testbench
====================================

Name: fc_feature_packer

Overview:
Producer side of the FC input interface. Collects a serial stream of normalized Q16.8 samples (one per accepted beat) into the 30-entry parallel vector the FC layer consumes on i_data, and holds it stable until FC acknowledges. Double-buffered: fill buffer accepts the next frame while the published vector is held. Sits between the per-sample normalizer and FC.

Parameters:
N_FEAT, 30, entries per frame (FC input width)
DATA_W, 24, sample width, signed Q16.8 (SF = 2^-8)
CNT_W, 8, width of published-frame counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_clear  in  1  sync abort: discard partial frame, drop o_valid
i_valid  in  1  sample valid from normalizer
i_sample  in  DATA_W  signed Q16.8 sample
o_ready  out  1  packer can accept a sample this cycle
o_data  out  N_FEAT x DATA_W  published vector, entry 0 = first sample of frame; drives FC i_data
o_valid  out  1  o_data holds a complete, unconsumed frame
i_ack  in  1  FC has consumed o_data (single-cycle pulse)
o_frame_cnt  out  CNT_W  frames published since reset, wraps

Behaviour:
- Reset (async, i_rst_n=0): state FILL, idx=0, fill buffer and o_data all 0, o_valid=0, o_frame_cnt=0; o_ready=1 once reset releases.
- States: FILL (accepting), HOLD (fill complete, output slot occupied).
- o_ready = (state==FILL); registered-state decode only, no combinational path from i_valid/i_ack.
- Accept = i_valid && o_ready. On accept: fill[idx] <= i_sample, idx++. i_valid while !o_ready: sample ignored, no side effects (producer must hold).
- Slot free = !o_valid || i_ack (ack and refill in same cycle allowed).
- Accept with idx==N_FEAT-1:
  - slot free: next edge o_data <= fill with this sample in entry N_FEAT-1, o_valid=1, o_frame_cnt++, idx=0, stay FILL. Latency: last sample edge k -> o_valid high in cycle k+1.
  - slot busy: fill[N_FEAT-1] written, idx=0, go HOLD.
- HOLD: o_ready=0; on i_ack: o_data <= fill, o_valid stays 1, o_frame_cnt++, go FILL.
- i_ack with o_valid=1 and no transfer that cycle: o_valid=0 next edge; o_data retained. i_ack with o_valid=0: ignored.
- i_clear (priority over accept/ack): idx=0, state FILL, o_valid=0; o_data, fill contents and o_frame_cnt unchanged. Partial frame is never published.
- Samples stored bit-exact; no arithmetic, saturation or sign change. Values are two's complement.
- o_frame_cnt wraps 2^CNT_W-1 -> 0.
- o_data changes only on a publish edge; stable for the whole o_valid window.

Decomposition:
- Shared package fc_pkg: N_FEAT, DATA_W, FRAC_BITS=8, typedef fc_sample_t (signed [DATA_W-1:0]), fc_vec_t (fc_sample_t [0:N_FEAT-1]), state enum {FILL, HOLD}. FC and this block both import it.
- Single module; counter and FSM inline, no sub-module.

Test Plan:
- Reset release -> o_ready=1, o_valid=0, o_data all 0, o_frame_cnt=0; async assert mid-frame clears everything without a clock edge.
- Stream 30 samples back-to-back, i_valid=1: sample0=24'hFF1821 (-0x00e7df), sample3=24'h00D557, sample29=24'hFF53CC (-0x00ac34) -> o_valid rises cycle after 30th accept, o_data[0]=FF1821, [3]=00D557, [29]=FF53CC, o_frame_cnt=1.
- No ack, stream 30 more -> after 30th, o_ready=0 (HOLD), o_data still frame 1; pulse i_ack -> next edge o_data = frame 2, o_valid stays 1, o_ready=1, o_frame_cnt=2.
- 30th sample of frame 2 accepted in same cycle as i_ack of frame 1 -> o_valid never drops, o_data = frame 2 next edge, no HOLD entry.
- After 12 samples assert i_clear -> idx=0, o_valid=0; following 30 samples publish with entry 0 = first post-clear sample.
- i_ack with o_valid=0, and i_valid during HOLD -> no state change, those samples absent from the next published frame; 256 frames -> o_frame_cnt wraps to 0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared FC input-interface types: sample format, feature vector and packer states.
// Samples are signed Q16.8 and are carried bit-exact.
package fc_pkg;
  localparam int N_FEAT    = 30;
  localparam int DATA_W    = 24;
  localparam int FRAC_BITS = 8;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = $clog2(N_FEAT);

  typedef logic signed [DATA_W-1:0] fc_sample_t;
  typedef fc_sample_t [0:N_FEAT-1]  fc_vec_t;

  typedef enum logic {FILL, HOLD} fc_state_t;
endpackage

// File: rtl/fc_feature_packer_if.sv
// Handshake bundle between the sample normalizer, the feature packer and the FC layer.
// The slave modport is the packer's view; master is the driving side.
interface fc_feature_packer_if;
  import fc_pkg::*;

  logic             i_clear;
  logic             i_valid;
  fc_sample_t       i_sample;
  logic             o_ready;
  fc_vec_t          o_data;
  logic             o_valid;
  logic             i_ack;
  logic [CNT_W-1:0] o_frame_cnt;

  modport slave (
    input  i_clear, i_valid, i_sample, i_ack,
    output o_ready, o_data, o_valid, o_frame_cnt
  );

  modport master (
    output i_clear, i_valid, i_sample, i_ack,
    input  o_ready, o_data, o_valid, o_frame_cnt
  );
endinterface

// File: rtl/fc_feature_packer.sv
// Packs a serial Q16.8 sample stream into a 30-entry FC input vector.
// Double-buffered: the fill buffer takes the next frame while o_data is held for FC.
module fc_feature_packer
  import fc_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  fc_feature_packer_if.slave io_bus
);

  fc_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  fc_vec_t          r_fill, w_fill_nxt;
  fc_vec_t          r_data;
  logic             r_valid, w_valid_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_last, w_slot_free, w_publish;

  assign w_accept    = io_bus.i_valid && (r_state == FILL);
  assign w_last      = (r_idx == IDX_W'(N_FEAT-1));
  assign w_slot_free = !r_valid || io_bus.i_ack;

  // Clear wins over accept and ack; it never touches fill contents, o_data or the count.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_fill_nxt  = r_fill;
    w_valid_nxt = r_valid;
    w_publish   = 1'b0;
    if (io_bus.i_clear) begin
      w_state_nxt = FILL;
      w_idx_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      if (io_bus.i_ack) w_valid_nxt = 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            w_fill_nxt[r_idx] = io_bus.i_sample;
            if (w_last) begin
              w_idx_nxt = '0;
              if (w_slot_free) begin
                w_publish   = 1'b1;
                w_valid_nxt = 1'b1;
              end else begin
                w_state_nxt = HOLD;
              end
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (io_bus.i_ack) begin
            w_publish   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = FILL;
          end
        end
        default: w_state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_fill  <= w_fill_nxt;
      r_valid <= w_valid_nxt;
      // Publishing from w_fill_nxt lets the last sample land in o_data on its own edge.
      if (w_publish) begin
        r_data <= w_fill_nxt;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign io_bus.o_ready     = (r_state == FILL);
  assign io_bus.o_data      = r_data;
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_frame_cnt = r_cnt;

endmodule

// File: tb/tb_fc_feature_packer.sv
// Scenario bench for fc_feature_packer: a reference model queues every completed frame
// and each scenario pops and compares when the packer publishes.
module tb_fc_feature_packer;
  import fc_pkg::*;

  logic i_clk;
  logic i_rst_n;
  fc_feature_packer_if bus();

  fc_feature_packer dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .io_bus  (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int               n_checks;
  int               n_fail;
  fc_vec_t          exp_q[$];
  fc_vec_t          m_fill;
  int               m_idx;
  logic [CNT_W-1:0] m_cnt;
  fc_vec_t          last_pub;

  // Entered and left at a negedge; the model accepts only if o_ready was high that cycle.
  task automatic send(input fc_sample_t v, input logic ack);
    logic acc;
    bus.i_valid  = 1'b1;
    bus.i_sample = v;
    bus.i_ack    = ack;
    acc = bus.o_ready;
    @(posedge i_clk);
    if (acc) begin
      m_fill[m_idx] = v;
      if (m_idx == N_FEAT-1) begin
        exp_q.push_back(m_fill);
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    bus.i_ack   = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.i_ack = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.o_data); end
    n_checks++;
    if (bus.o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.o_frame_cnt); end
  endtask

  task automatic test_first_frame();
    fc_sample_t s;
    for (int i = 0; i < N_FEAT; i++) begin
      s = DATA_W'($urandom);
      if (i == 0)  s = 24'hFF1821;
      if (i == 3)  s = 24'h00D557;
      if (i == 29) s = 24'hFF53CC;
      send(s, 1'b0);
    end
    m_cnt++;
    last_pub = exp_q.pop_front();
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", bus.o_valid); end
    n_checks++;
    if (bus.o_data[0] !== 24'hFF1821) begin n_fail++; $display("FAIL first_e0 got %h want ff1821", bus.o_data[0]); end
    n_checks++;
    if (bus.o_data[3] !== 24'h00D557) begin n_fail++; $display("FAIL first_e3 got %h want 00d557", bus.o_data[3]); end
    n_checks++;
    if (bus.o_data[29] !== 24'hFF53CC) begin n_fail++; $display("FAIL first_e29 got %h want ff53cc", bus.o_data[29]); end
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL first_data got %h want %h", bus.o_data, last_pub); end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL first_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < N_FEAT; i++) send(DATA_W'($urandom), 1'b0);
    n_checks++;
    if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %b want 0", bus.o_ready); end
    // Samples offered while holding must not reach any frame.
    for (int i = 0; i < 3; i++) send(DATA_W'($urandom), 1'b0);
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL hold_data got %h want %h", bus.o_data, last_pub); end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL hold_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
    pulse_ack();
    m_cnt++;
    last_pub = exp_q.pop_front();
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL hold_pub_data got %h want %h", bus.o_data, last_pub); end
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL hold_pub_valid got %b want 1", bus.o_valid); end
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL hold_pub_ready got %b want 1", bus.o_ready); end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL hold_pub_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
  endtask

  task automatic test_ack_refill();
    for (int i = 0; i < N_FEAT-1; i++) send(DATA_W'($urandom), 1'b0);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL refill_pre_valid got %b want 1", bus.o_valid); end
    send(DATA_W'($urandom), 1'b1);
    m_cnt++;
    last_pub = exp_q.pop_front();
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL refill_valid got %b want 1", bus.o_valid); end
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready got %b want 1", bus.o_ready); end
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL refill_data got %h want %h", bus.o_data, last_pub); end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL refill_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 12; i++) send(DATA_W'($urandom), 1'b0);
    // A sample offered alongside clear must be dropped.
    bus.i_clear = 1'b1;
    send(DATA_W'($urandom), 1'b0);
    bus.i_clear = 1'b0;
    m_idx = 0;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL clear_data got %h want %h", bus.o_data, last_pub); end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL clear_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
    for (int i = 0; i < N_FEAT; i++) send(DATA_W'($urandom), 1'b0);
    m_cnt++;
    last_pub = exp_q.pop_front();
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL clear_pub_data got %h want %h", bus.o_data, last_pub); end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL clear_pub_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
  endtask

  task automatic test_ack_idle();
    pulse_ack();
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL ack_data got %h want %h", bus.o_data, last_pub); end
    pulse_ack();
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ack got valid=%b ready=%b want valid=0 ready=1", bus.o_valid, bus.o_ready);
    end
    n_checks++;
    if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL idle_ack_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
  endtask

  task automatic test_wrap();
    int frames;
    frames = 256 - int'(m_cnt);
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < N_FEAT-1; i++) send(DATA_W'($urandom), 1'b0);
      send(DATA_W'($urandom), (f != 0));
      m_cnt++;
      last_pub = exp_q.pop_front();
      n_checks++;
      if (bus.o_data !== last_pub) begin n_fail++; $display("FAIL wrap_data f=%0d got %h want %h", f, bus.o_data, last_pub); end
      if (m_cnt == 8'hFF || m_cnt == 8'h00) begin
        n_checks++;
        if (bus.o_frame_cnt !== m_cnt) begin n_fail++; $display("FAIL wrap_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) send(DATA_W'($urandom), 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_data !== '0) begin n_fail++; $display("FAIL async_data got %h want 0", bus.o_data); end
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_flags got valid=%b ready=%b want valid=0 ready=1", bus.o_valid, bus.o_ready);
    end
    n_checks++;
    if (bus.o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL async_cnt got %0d want 0", bus.o_frame_cnt); end
    m_idx  = 0;
    m_fill = '0;
    m_cnt  = '0;
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    // Fill buffer must have been cleared too: a fresh frame publishes exactly what was sent.
    for (int i = 0; i < N_FEAT; i++) send(DATA_W'($urandom), 1'b0);
    m_cnt++;
    last_pub = exp_q.pop_front();
    n_checks++;
    if (bus.o_data !== last_pub || bus.o_frame_cnt !== m_cnt) begin
      n_fail++; $display("FAIL async_refill got cnt=%0d data=%h want cnt=%0d data=%h", bus.o_frame_cnt, bus.o_data, m_cnt, last_pub);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    m_idx        = 0;
    m_fill       = '0;
    m_cnt        = '0;
    last_pub     = '0;
    bus.i_clear  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_sample = '0;
    bus.i_ack    = 1'b0;
    i_rst_n      = 1'b0;
    test_reset();
    test_first_frame();
    test_hold();
    test_ack_refill();
    test_clear();
    test_ack_idle();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
